// File: rtl/pyon_pkg.sv
// Shared definitions for the pyon ladder renderer: screen geometry, default
// box placement, FSM state encoding, colour constants and a width helper.
// Optional feature macro: PYON_CLEAR_EN adds the full-screen CLEAR state.
package pyon_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int MAX_STEP = 32;

    // Default box geometry and the left edge of each player's column
    localparam int DEF_BOX_W = 8;
    localparam int DEF_BOX_H = 3;
    localparam int DEF_P0_X  = 32;
    localparam int DEF_P1_X  = 104;
    localparam int DEF_Y_BOT = 116;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1
`ifdef PYON_CLEAR_EN
        ,
        ST_CLEAR = 2'd2
`endif
    } state_t;

    // Counter width able to hold 0..n-1 (at least one bit)
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pyon_raster_counter.sv
// Two-dimensional raster position counter: col runs fastest over
// 0..WIDTH-1, then row over 0..HEIGHT-1, wrapping back to (0,0).
// Used for both the box scan and the full-screen clear scan.
module pyon_raster_counter
    import pyon_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 3,
    localparam int COL_W = cnt_bits(WIDTH),
    localparam int ROW_W = cnt_bits(HEIGHT)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(WIDTH - 1));
    assign row_end = (row == ROW_W'(HEIGHT - 1));
    assign last    = col_end & row_end;

    // Position register: restart at origin, or step one pixel in raster order
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation order cannot change results.
    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pyon_box_drawer.sv
// Rasterises one ladder box per accepted draw request into a burst of
// registered pixel writes for the 160x120 VGA adapter plot port.
// Optional feature macro: PYON_CLEAR_EN clears the whole screen after reset.
module pyon_box_drawer
    import pyon_pkg::*;
#(
    parameter int BOX_W    = DEF_BOX_W,
    parameter int BOX_H    = DEF_BOX_H,
    parameter int P0_X     = DEF_P0_X,
    parameter int P1_X     = DEF_P1_X,
    parameter int Y_BOT    = DEF_Y_BOT,
    parameter int MAX_STEP = pyon_pkg::MAX_STEP
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_player,
    input  logic [5:0] req_step,
    input  logic       req_side,
    input  logic [2:0] req_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       err
);

    localparam int BCW = cnt_bits(BOX_W);
    localparam int BRW = cnt_bits(BOX_H);

`ifdef PYON_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic   RESET_READY = 1'b0;
`else
    localparam state_t RESET_STATE = ST_IDLE;
    localparam logic   RESET_READY = 1'b1;
`endif

    state_t         state;
    logic [7:0]     box_x;      // left column of the box being drawn
    logic [6:0]     box_y;      // top row of the box being drawn
    logic           accept;
    logic           step_ok;
    logic [7:0]     req_x;
    logic [6:0]     req_y;
    logic           box_start;
    logic           box_advance;
    logic [BCW-1:0] box_col;
    logic [BRW-1:0] box_row;
    logic           box_last;
    logic [7:0]     next_x;
    logic [6:0]     next_y;

    assign accept  = req_valid & req_ready;
    assign step_ok = ({3'b000, req_step} <= 9'(MAX_STEP));

    // Box origin from the request, computed in 9 bits then truncated
    assign req_x = 8'((req_player ? 9'(P1_X) : 9'(P0_X)) + (req_side ? 9'(BOX_W) : 9'd0));
    assign req_y = 7'(9'(Y_BOT) - ({3'b000, req_step} * 9'(BOX_H)));

    assign box_start   = (state == ST_IDLE) && accept && step_ok;
    assign box_advance = (state == ST_DRAW) && !box_last;

    pyon_raster_counter #(
        .WIDTH  (BOX_W),
        .HEIGHT (BOX_H)
    ) u_box_scan (
        .clk     (clk),
        .resetn  (resetn),
        .start   (box_start),
        .advance (box_advance),
        .col     (box_col),
        .row     (box_row),
        .last    (box_last)
    );

`ifdef PYON_CLEAR_EN
    logic [7:0] clr_col;
    logic [6:0] clr_row;
    logic       clr_last;

    pyon_raster_counter #(
        .WIDTH  (SCREEN_W),
        .HEIGHT (SCREEN_H)
    ) u_clear_scan (
        .clk     (clk),
        .resetn  (resetn),
        .start   (1'b0),
        .advance (state == ST_CLEAR),
        .col     (clr_col),
        .row     (clr_row),
        .last    (clr_last)
    );
`endif

    // Coordinates of the pixel that follows the one currently on the outputs
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_x = box_x;
        next_y = y;
        if (box_col != BCW'(BOX_W - 1)) begin
            next_x = box_x + 8'(box_col) + 8'd1;
        end else begin
            next_y = box_y + 7'(box_row) + 7'd1;
        end
    end

    // Control FSM with registered handshake and plot-port outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= RESET_STATE;
            req_ready <= RESET_READY;
            plot      <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            err       <= 1'b0;
            box_x     <= '0;
            box_y     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    plot      <= 1'b0;
                    if (accept) begin
                        if (step_ok) begin
                            state     <= ST_DRAW;
                            req_ready <= 1'b0;
                            plot      <= 1'b1;
                            x         <= req_x;
                            y         <= req_y;
                            colour    <= req_colour;
                            box_x     <= req_x;
                            box_y     <= req_y;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_DRAW: begin
                    if (box_last) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        plot      <= 1'b0;
                    end else begin
                        x <= next_x;
                        y <= next_y;
                    end
                end
`ifdef PYON_CLEAR_EN
                ST_CLEAR: begin
                    plot   <= 1'b1;
                    x      <= clr_col;
                    y      <= clr_row;
                    colour <= BLACK;
                    if (clr_last) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pyon_box_drawer.sv
// Self-checking bench for pyon_box_drawer: a queue-of-pixels reference
// model predicts every cycle of the plot port and handshake.
// Honours PYON_CLEAR_EN when the design is built with it.
module tb_pyon_box_drawer;

    typedef struct {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_player = 1'b0;
    logic [5:0] req_step = '0;
    logic       req_side = 1'b0;
    logic [2:0] req_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    pix_t       q[$];
    bit         m_ready = 1'b1;
    bit         m_plot = 1'b0;
    bit         m_err = 1'b0;
    logic [7:0] m_x = '0;
    logic [6:0] m_y = '0;
    logic [2:0] m_c = '0;
    bit         m_accepted = 1'b0;
    bit         prev_plot = 1'b0;
    int         rise_q[$];

    pyon_box_drawer dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_player (req_player),
        .req_step   (req_step),
        .req_side   (req_side),
        .req_colour (req_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs
    task automatic step_cycle();
        pix_t p;
        int   bx;
        int   by;
        @(posedge clk);
        cyc++;
        if (!resetn) begin
            q.delete();
            m_plot = 1'b0;
            m_err  = 1'b0;
            m_x    = '0;
            m_y    = '0;
            m_c    = '0;
`ifdef PYON_CLEAR_EN
            m_ready = 1'b0;
            for (int yy = 0; yy < 120; yy++)
                for (int xx = 0; xx < 160; xx++) begin
                    p.px = 8'(xx);
                    p.py = 7'(yy);
                    p.pc = 3'b000;
                    q.push_back(p);
                end
`else
            m_ready = 1'b1;
`endif
        end else begin
            if (req_valid && m_ready) begin
                m_accepted = 1'b1;
                if (int'(req_step) > 32) begin
                    m_err = 1'b1;
                end else begin
                    bx = (req_player ? 104 : 32) + (req_side ? 8 : 0);
                    by = 116 - int'(req_step) * 3;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 8; c++) begin
                            p.px = 8'(bx + c);
                            p.py = 7'(by + r);
                            p.pc = req_colour;
                            q.push_back(p);
                        end
                end
            end
            if (q.size() > 0) begin
                p       = q.pop_front();
                m_plot  = 1'b1;
                m_ready = 1'b0;
                m_x     = p.px;
                m_y     = p.py;
                m_c     = p.pc;
            end else begin
                m_plot  = 1'b0;
                m_ready = 1'b1;
            end
        end
        #1;
        check("ready", 32'(req_ready), 32'(m_ready));
        check("plot", 32'(plot), 32'(m_plot));
        check("err", 32'(err), 32'(m_err));
        check("x", 32'(x), 32'(m_x));
        check("y", 32'(y), 32'(m_y));
        check("colour", 32'(colour), 32'(m_c));
        if (plot && !prev_plot) rise_q.push_back(cyc);
        prev_plot = plot;
    endtask

    // Hold a request until the handshake completes (bounded)
    task automatic send(input bit pl, input int st, input bit sd, input logic [2:0] c);
        req_player = pl;
        req_step   = 6'(st);
        req_side   = sd;
        req_colour = c;
        req_valid  = 1'b1;
        m_accepted = 1'b0;
        for (int i = 0; i < 200 && !m_accepted; i++) step_cycle();
        if (!m_accepted) check("accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    // After reset the clear scan must finish; requests during it are ignored
    task automatic wait_clear();
`ifdef PYON_CLEAR_EN
        req_player = 1'b0;
        req_step   = 6'd5;
        req_colour = 3'b111;
        req_valid  = 1'b1;
        repeat (19200) step_cycle();
        req_valid = 1'b0;
        repeat (3) step_cycle();
`endif
    endtask

    // Follow one box from its first pixel, checking spec-given corners
    task automatic check_box(input string tag, input int fx, input int fy,
                             input int lx_exp, input int ly_exp, input logic [2:0] c);
        int n;
        int lx;
        int ly;
        check({tag, "_first_plot"}, 32'(plot), 1);
        check({tag, "_first_x"}, 32'(x), 32'(fx));
        check({tag, "_first_y"}, 32'(y), 32'(fy));
        check({tag, "_colour"}, 32'(colour), 32'(c));
        n  = 1;
        lx = int'(x);
        ly = int'(y);
        for (int i = 0; i < 100 && plot; i++) begin
            step_cycle();
            if (plot) begin
                n++;
                lx = int'(x);
                ly = int'(y);
            end
        end
        check({tag, "_plot_cycles"}, 32'(n), 24);
        check({tag, "_last_x"}, 32'(lx), 32'(lx_exp));
        check({tag, "_last_y"}, 32'(ly), 32'(ly_exp));
        check({tag, "_ready_after"}, 32'(req_ready), 1);
    endtask

    initial begin
        // Reset
        resetn = 1'b0;
        repeat (2) step_cycle();
`ifdef PYON_CLEAR_EN
        check("rst_ready", 32'(req_ready), 0);
`else
        check("rst_ready", 32'(req_ready), 1);
`endif
        check("rst_plot", 32'(plot), 0);
        check("rst_err", 32'(err), 0);
        resetn = 1'b1;
        wait_clear();
        step_cycle();

        // Player 0, step 0, left box
        send(1'b0, 0, 1'b0, 3'b010);
        check_box("p0s0", 32, 116, 39, 118, 3'b010);
        repeat (3) step_cycle();

        // Player 1, top step, right box
        send(1'b1, 32, 1'b1, 3'b100);
        check_box("p1s32", 112, 20, 119, 22, 3'b100);
        repeat (3) step_cycle();

        // Out-of-range step: flagged, nothing drawn, still ready
        send(1'b0, 33, 1'b0, 3'b001);
        check("bad_err", 32'(err), 1);
        check("bad_plot", 32'(plot), 0);
        check("bad_ready", 32'(req_ready), 1);
        repeat (5) step_cycle();
        check("bad_err_sticky", 32'(err), 1);

        // Two queued requests with req_valid held high throughout
        rise_q.delete();
        send(1'b0, 3, 1'b1, 3'b011);
        send(1'b1, 7, 1'b0, 3'b110);
        repeat (60) step_cycle();
        check("b2b_bursts", 32'(rise_q.size()), 2);
        if (rise_q.size() >= 2) check("b2b_spacing", 32'(rise_q[1] - rise_q[0]), 25);

        // Reset during the 10th plot cycle of a box
        send(1'b1, 10, 1'b1, 3'b101);
        repeat (9) step_cycle();
        check("mid_in_draw", 32'(plot), 1);
        resetn = 1'b0;
        step_cycle();
        check("mid_rst_plot", 32'(plot), 0);
        check("mid_rst_err", 32'(err), 0);
        // Reset together with a valid request: reset wins
        req_valid = 1'b1;
        step_cycle();
        req_valid = 1'b0;
        resetn    = 1'b1;
        step_cycle();
        check("rst_vs_valid_plot", 32'(plot), 0);
        wait_clear();

        // Randomised traffic, including some illegal steps
        for (int k = 0; k < 30; k++) begin
            send(1'($urandom_range(0, 1)), int'($urandom_range(0, 36)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 30)) step_cycle();
        end
        repeat (30) step_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
